// File: rtl/regfile_4x8.sv
// regfile_4x8: four-entry register file with two combinational read ports,
// a registered debug/display port and a saturating committed-write counter.
// Optional build macro: REGFILE_BYPASS_EN enables write-through forwarding
// on the combinational read ports.
module regfile_4x8 #(
    parameter int unsigned           DATA_W    = 8,
    parameter logic [DATA_W-1:0]     RESET_VAL = '0,
    parameter int unsigned           CNT_W     = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [1:0]        read_reg1,
    input  logic [1:0]        read_reg2,
    input  logic [1:0]        write_reg,
    input  logic [DATA_W-1:0] write_data,
    input  logic              reg_write,
    output logic [DATA_W-1:0] read_data1,
    output logic [DATA_W-1:0] read_data2,
    input  logic [1:0]        dbg_sel,
    output logic [DATA_W-1:0] dbg_data,
    output logic [CNT_W-1:0]  wr_count
);

    localparam int unsigned NUM_REGS = 4;

    logic [DATA_W-1:0] regs_q [NUM_REGS];
    logic [DATA_W-1:0] regs_d [NUM_REGS];
    logic [DATA_W-1:0] dbg_q;
    logic [DATA_W-1:0] dbg_d;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_d;

    // Next register contents: the addressed entry takes write_data when enabled.
    always_comb begin
        regs_d = regs_q;
        if (reg_write) begin
            regs_d[write_reg] = write_data;
        end
    end

    // Debug capture sees the post-edge value, so a write to dbg_sel shows up directly.
    always_comb begin
        dbg_d = regs_d[dbg_sel];
    end

    // Committed-write counter saturates at all-ones instead of wrapping.
    always_comb begin
        cnt_d = cnt_q;
        if (reg_write && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // State update; reset clears everything immediately and wins over a write.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < int'(NUM_REGS); i++) begin
                regs_q[i] <= RESET_VAL;
            end
            dbg_q <= '0;
            cnt_q <= '0;
        end else begin
            regs_q <= regs_d;
            dbg_q  <= dbg_d;
            cnt_q  <= cnt_d;
        end
    end

    // Read port 1: stored value, optionally forwarded from a same-cycle write.
    always_comb begin
        read_data1 = regs_q[read_reg1];
`ifdef REGFILE_BYPASS_EN
        if (reg_write && (write_reg == read_reg1)) begin
            read_data1 = write_data;
        end
`endif
    end

    // Read port 2: same behaviour as port 1, independently.
    always_comb begin
        read_data2 = regs_q[read_reg2];
`ifdef REGFILE_BYPASS_EN
        if (reg_write && (write_reg == read_reg2)) begin
            read_data2 = write_data;
        end
`endif
    end

    assign dbg_data = dbg_q;
    assign wr_count = cnt_q;

endmodule

// File: tb/tb_regfile_4x8.sv
// Bench for regfile_4x8: directed vectors, literal expectations and a
// per-cycle comparison against a behavioural model of the register file.
module tb_regfile_4x8;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [1:0] read_reg1, read_reg2, write_reg, dbg_sel;
    logic [7:0] write_data;
    logic       reg_write;
    logic [7:0] read_data1, read_data2, dbg_data, wr_count;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    regfile_4x8 dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .read_reg1  (read_reg1),
        .read_reg2  (read_reg2),
        .write_reg  (write_reg),
        .write_data (write_data),
        .reg_write  (reg_write),
        .read_data1 (read_data1),
        .read_data2 (read_data2),
        .dbg_sel    (dbg_sel),
        .dbg_data   (dbg_data),
        .wr_count   (wr_count)
    );

    always #5 clk = ~clk;

    // Behavioural model: register array, debug copy and saturating count.
    logic [7:0] mdl [4] = '{8'h00, 8'h00, 8'h00, 8'h00};
    logic [7:0] mdbg = 8'h00;
    int         mcnt = 0;

    always @(posedge clk or negedge reset_n) begin : model
        logic [7:0] nxt [4];
        if (!reset_n) begin
            for (int i = 0; i < 4; i++) mdl[i] <= 8'h00;
            mdbg <= 8'h00;
            mcnt <= 0;
        end else begin
            nxt = mdl;
            if (reg_write) nxt[write_reg] = write_data;
            mdl  <= nxt;
            mdbg <= nxt[dbg_sel];
            if (reg_write && mcnt < 255) mcnt <= mcnt + 1;
        end
    end

    function automatic logic [7:0] exp_rd(input logic [1:0] a);
`ifdef REGFILE_BYPASS_EN
        if (reg_write && write_reg == a) return write_data;
`endif
        return mdl[a];
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_en && reset_n) begin
            check("rd1_model", read_data1, exp_rd(read_reg1));
            check("rd2_model", read_data2, exp_rd(read_reg2));
            check("dbg_model", dbg_data, mdbg);
            check("cnt_model", wr_count, 8'(mcnt));
        end
    end

    task automatic wr(input logic [1:0] a, input logic [7:0] d);
        write_reg  = a;
        write_data = d;
        reg_write  = 1'b1;
        @(posedge clk);
        #1 reg_write = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0; reg_write = 1'b0; write_reg = 2'd0; write_data = 8'h00;
        read_reg1 = 2'd0; read_reg2 = 2'd0; dbg_sel = 2'd0;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        chk_en = 1'b1;

        // Reset state after release
        #1;
        check("rst_rd1", read_data1, 8'h00);
        check("rst_cnt", wr_count, 8'h00);

        // Mid-cycle reset after a write to r2
        wr(2'd2, 8'h5A);
        read_reg1 = 2'd2; read_reg2 = 2'd2;
        #1 check("pre_rst_r2", read_data1, 8'h5A);
        check("pre_rst_cnt", wr_count, 8'h01);
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        check("async_rst_rd1", read_data1, 8'h00);
        check("async_rst_rd2", read_data2, 8'h00);
        check("async_rst_cnt", wr_count, 8'h00);
        check("async_rst_dbg", dbg_data, 8'h00);
        @(posedge clk);
        #1 reset_n = 1'b1;

        // Basic write/read on consecutive edges
        wr(2'd0, 8'h11);
        wr(2'd1, 8'h22);
        wr(2'd2, 8'h33);
        wr(2'd3, 8'h44);
        read_reg1 = 2'd3; read_reg2 = 2'd1;
        #1;
        check("basic_rd1", read_data1, 8'h44);
        check("basic_rd2", read_data2, 8'h22);
        check("basic_cnt", wr_count, 8'h04);

        // Write disabled for three edges
        write_reg = 2'd2; write_data = 8'hFF; reg_write = 1'b0;
        repeat (3) @(posedge clk);
        #1 read_reg1 = 2'd2;
        #1;
        check("nowr_r2", read_data1, 8'h33);
        check("nowr_cnt", wr_count, 8'h04);

        // Same-cycle read/write of r1; both ports on r1
        read_reg1 = 2'd1; read_reg2 = 2'd1;
        write_reg = 2'd1; write_data = 8'h99; reg_write = 1'b1;
        #1;
`ifdef REGFILE_BYPASS_EN
        check("rw_same_pre", read_data1, 8'h99);
        check("rw_same_pre2", read_data2, 8'h99);
`else
        check("rw_same_pre", read_data1, 8'h22);
        check("rw_same_pre2", read_data2, 8'h22);
`endif
        @(posedge clk);
        #1 reg_write = 1'b0;
        check("rw_same_post", read_data1, 8'h99);
        check("rw_same_post2", read_data2, 8'h99);
        check("rw_cnt", wr_count, 8'h05);

        // Debug port latency
        check("dbg_init", dbg_data, 8'h11);
        dbg_sel = 2'd3;
        wr(2'd3, 8'hC3);
        check("dbg_wr_r3", dbg_data, 8'hC3);
        dbg_sel = 2'd0;
        #1 check("dbg_hold", dbg_data, 8'hC3);
        @(posedge clk);
        #1 check("dbg_sel_r0", dbg_data, 8'h11);
        check("dbg_cnt", wr_count, 8'h06);

        // Counter saturation: 300 writes starting from a count of 6
        for (int i = 0; i < 300; i++) begin
            read_reg1 = 2'(i + 1);
            read_reg2 = 2'(i);
            dbg_sel   = 2'(i >> 2);
            wr(2'(i), 8'(i * 7));
            if (i == 247) check("sat_fe", wr_count, 8'hFE);
            if (i == 248) check("sat_ff", wr_count, 8'hFF);
        end
        check("sat_hold", wr_count, 8'hFF);
        read_reg1 = 2'd3;
        #1 check("sat_last_r3", read_data1, 8'(299 * 7));

        // Reset pulse clears the saturated counter
        #2 reset_n = 1'b0;
        #1 check("sat_rst_cnt", wr_count, 8'h00);
        check("sat_rst_rd1", read_data1, 8'h00);
        #1 reset_n = 1'b1;
        repeat (2) @(posedge clk);
        #1 check("post_rst_cnt", wr_count, 8'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/regfile_4x8.md
Name: regfile_4x8

Overview:
- Four-entry general-purpose register file for the single-cycle CPU. It sits directly downstream of the write-register select mux.
- Its write address is the mux's 2-bit output, chosen from inst[3:2] or inst[1:0] by RegDst.
- Provides two combinational read ports for the ALU/operand path and a registered debug port for the board display.
- Keeps a saturating count of committed register writes.

Parameters:
- DATA_W, 8, width of each register and of all data ports.
- RESET_VAL, 0, value loaded into every register on reset. Width DATA_W.
- CNT_W, 8, width of the write counter.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- read_reg1  input  2  read port 1 address (inst[7:6]).
- read_reg2  input  2  read port 2 address (inst[5:4]).
- write_reg  input  2  write address; driven by the write-register select mux output.
- write_data  input  DATA_W  write-back data (ALU result or memory data).
- reg_write  input  1  write enable from the control unit.
- read_data1  output  DATA_W  contents of register read_reg1.
- read_data2  output  DATA_W  contents of register read_reg2.
- dbg_sel  input  2  register selected for the display.
- dbg_data  output  DATA_W  registered copy of the selected register.
- wr_count  output  CNT_W  number of committed writes since reset, saturating.

Behaviour:
- Clock and reset: single clock clk. Reset is asynchronous and active-low on reset_n.
- While reset_n=0:
  - regs[0..3] = RESET_VAL
  - dbg_data = 0
  - wr_count = 0
  - Reset takes effect immediately, without waiting for a clock edge, and overrides any write in progress.
- Release: the first write can occur at the first rising clk edge with reset_n=1.
- Write:
  - At posedge clk, if reg_write=1, regs[write_reg] <= write_data.
  - If reg_write=0, no register changes.
  - All four registers are writable; there is no hard-wired zero register.
- Read:
  - read_dataN = regs[read_regN], purely combinational, zero latency.
  - Without the optional feature, a read of the register being written in the same cycle returns the OLD value. The new value is visible after the edge.
  - Both read ports may address the same register, with or without a concurrent write; there is no conflict.
- Debug port:
  - At each posedge, dbg_data <= post-edge contents of regs[dbg_sel].
  - If reg_write=1 and write_reg==dbg_sel, the captured value is write_data.
  - Latency: exactly 1 cycle from a dbg_sel change or a write.
- Write counter:
  - At posedge, if reg_write=1 and wr_count != all-ones, wr_count <= wr_count+1.
  - At all-ones the count holds; it does not wrap.
  - It counts every write, including writes of an unchanged value.
- No X propagation: every output is defined after reset.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined (write-through forwarding):
  - If reg_write=1 and write_reg==read_regN, read_dataN = write_data combinationally in the same cycle.
  - Applies independently to each read port.
  - Debug port and counter are unchanged.
- Undefined: reads always return stored register contents (old value on a same-cycle read/write).

Test Plan:
- Reset: assert reset_n=0 mid-cycle after writing 0x5A to r2 -> all read ports return 0x00 immediately; wr_count=0; dbg_data=0.
- Basic write/read: write r0=0x11, r1=0x22, r2=0x33, r3=0x44 on consecutive edges, then read_reg1=3, read_reg2=1 -> read_data1=0x44, read_data2=0x22; wr_count=4.
- Write disabled: reg_write=0 with write_reg=2, write_data=0xFF for 3 edges -> r2 unchanged (0x33); wr_count unchanged.
- Same-cycle read/write of r1 (old 0x22, new 0x99), sampled before the edge:
  - Without REGFILE_BYPASS_EN: read_data1=0x22.
  - With REGFILE_BYPASS_EN: read_data1=0x99.
  - After the edge, both builds read 0x99.
- Debug latency: dbg_sel=3 while writing r3=0xC3 -> dbg_data=0xC3 exactly one edge later; change dbg_sel to 0 -> dbg_data=0x11 one edge later.
- Counter saturation: 300 consecutive writes -> wr_count reaches 0xFF at write 255 and holds 0xFF; reset_n pulse -> 0x00.
